// File: rtl/apb_req_arbiter_pkg.sv
// apb_arb_pkg: shared types and widths for the APB request arbiter slice.
//   APB_AW / APB_DW : APB address / data width used by arbiter, interface and bench
//   arb_state_e     : sequencer states
//   arb_req_t       : latched request (direction, address, write data)
package apb_arb_pkg;

  localparam int APB_AW = 12;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: request-side handshake plus the APB master command port.
//   master modport : arbiter view (drives grants, responses and the APB command)
//   slave modport  : requester/APB-master view (drives requests, read data, done)
//   req_addr/req_wdata are packed, requester i at [i*AW +: AW] / [i*DW +: DW].
interface apb_req_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = APB_AW,
  parameter int DW   = APB_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               transfer;
  logic               read_write;
  logic [AW-1:0]      apb_write_paddr;
  logic [AW-1:0]      apb_read_paddr;
  logic [DW-1:0]      apb_write_data;
  logic [DW-1:0]      apb_read_data_out;
  logic               apb_done;
  logic               busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, apb_read_data_out, apb_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, transfer, read_write,
           apb_write_paddr, apb_read_paddr, apb_write_data, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, apb_read_data_out, apb_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, transfer, read_write,
           apb_write_paddr, apb_read_paddr, apb_write_data, busy
  );

endinterface

// File: rtl/apb_req_arbiter_rr_pick.sv
// apb_rr_pick: combinational rotating-priority picker.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot winner (zero when nothing requested)
//   idx   : winner index
//   any   : at least one request present
module apb_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk from ptr upwards, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter/sequencer sharing one APB master command
// port between NREQ requesters, one transaction at a time.
//   pclk, preset : clock (rising edge) and asynchronous active-high reset
//   bus          : request handshake, responses and APB command (master modport)
//   TIMEOUT      : XFER cycles before abort with rsp_err; 0 disables
//
// state | meaning
// IDLE  | waiting; grants the round-robin winner combinationally
// XFER  | APB command driven from the latched request; waiting for apb_done
// RESP  | one-cycle rsp_valid to the owner; advance rr pointer
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input logic pclk,
  input logic preset,
  apb_req_arbiter_if.master bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e      state_q, state_d;
  arb_req_t        req_q, pick_req;
  logic [IW-1:0]   owner_q, rr_ptr_q, pick_idx;
  logic [NREQ-1:0] pick_grant;
  logic            pick_any;
  logic [CW-1:0]   cnt_q;
  logic [APB_DW-1:0] rsp_rdata_q;
  logic            rsp_err_q;
  logic            timeout_hit;

  apb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_req.write = bus.req_write[pick_idx];
    pick_req.addr  = bus.req_addr[int'(pick_idx) * APB_AW +: APB_AW];
    pick_req.wdata = bus.req_wdata[int'(pick_idx) * APB_DW +: APB_DW];
  end

  // cnt_q counts completed XFER cycles, so the TIMEOUT-th cycle sees TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_XFER) && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_XFER;
      ST_XFER: if (bus.apb_done || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready       = '0;
    bus.rsp_valid       = '0;
    bus.transfer        = 1'b0;
    bus.read_write      = 1'b0;
    bus.apb_write_paddr = '0;
    bus.apb_read_paddr  = '0;
    bus.apb_write_data  = '0;
    bus.busy            = (state_q != ST_IDLE);
    bus.rsp_rdata       = rsp_rdata_q;
    bus.rsp_err         = rsp_err_q;
    case (state_q)
      // Gated by preset so no grant is shown while reset is held.
      ST_IDLE: if (!preset) bus.req_ready = pick_grant;
      ST_XFER: begin
        bus.transfer   = 1'b1;
        bus.read_write = req_q.write;
        if (req_q.write) begin
          bus.apb_write_paddr = req_q.addr;
          bus.apb_write_data  = req_q.wdata;
        end else begin
          bus.apb_read_paddr  = req_q.addr;
        end
      end
      ST_RESP: bus.rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      req_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            req_q   <= pick_req;
            owner_q <= pick_idx;
          end
          cnt_q <= '0;
        end
        ST_XFER: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
          // apb_done takes precedence over a simultaneous timeout.
          if (bus.apb_done) begin
            rsp_rdata_q <= req_q.write ? '0 : bus.apb_read_data_out;
            rsp_err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr_q <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
          cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter and sequencer that shares the single APB master command port (transfer, read_write, write/read address, write data, read data) between NREQ requesters. It accepts one request at a time, drives the master for exactly one transaction, waits for completion or timeout, and returns the response to the owning requester. It sits between the testbench/SoC-side request agents and the two-slave APB master.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, shared address-width define, APB address width
- DW, shared data-width define, APB data width
- TIMEOUT, 64, max cycles in XFER before abort; 0 disables timeout
- pclk  in  1  clock, all logic on rising edge
- preset  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request pending, per requester
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant/accept pulse
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DW  read data, valid with rsp_valid (0 for writes)
- rsp_err  out  1  timeout abort flag, valid with rsp_valid
- transfer  out  1  APB master transfer request
- read_write  out  1  1 = write, 0 = read
- apb_write_paddr  out  AW  write address
- apb_read_paddr  out  AW  read address
- apb_write_data  out  DW  write data
- apb_read_data_out  in  DW  read data from master
- apb_done  in  1  master completion pulse (ACCESS phase with pready)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, XFER, RESP.
- IDLE: if any req_valid, pick winner w by rotating priority starting at rr_ptr; req_ready[w]=1 this cycle (combinational from req_valid and state); latch req_write/addr/wdata of w and w itself; go XFER. No req_valid: stay.
- XFER: transfer=1, read_write = latched write bit. Write: apb_write_paddr/apb_write_data = latched, apb_read_paddr = 0. Read: apb_read_paddr = latched, write bus = 0. All held constant for whole state. Timeout counter increments each cycle.
- apb_done in XFER: capture apb_read_data_out (reads) into rsp_rdata register, rsp_err=0, go RESP.
- Counter reaches TIMEOUT without apb_done: rsp_err=1, rsp_rdata=0, go RESP.
- apb_done and timeout same cycle: apb_done wins, rsp_err=0.
- RESP: transfer=0, rsp_valid[w]=1 for one cycle, rr_ptr=(w+1) mod NREQ, counter cleared, go IDLE.
- apb_done outside XFER: ignored.
- req_valid dropped before grant: no grant, no side effect. After req_ready, requester inputs are don't-care.

## Timing
- Reset (async, immediate): state IDLE, rr_ptr 0, counter 0, transfer 0, read_write 0, all address/data outputs 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0. In-flight transaction dropped with no response.
- req_ready at cycle N (IDLE) -> transfer high from N+1.
- apb_done at cycle M -> rsp_valid at M+1, transfer low at M+1, next req_ready earliest M+2.
- transfer always low for at least one cycle between transactions.
- Timeout: transfer high for exactly TIMEOUT cycles, rsp_valid with rsp_err on the next cycle.
- Counter width $clog2(TIMEOUT+1); saturates, no wrap.
- rsp_rdata and rsp_err hold their value until the next RESP.

## Structure
- Package apb_arb_pkg: state enum (IDLE, XFER, RESP) and a request struct {write, addr, wdata}.
- Sub-module apb_rr_pick: combinational rotating-priority picker (inputs req vector and rr_ptr; outputs one-hot grant, index, any).
- Top: FSM, latch registers, timeout counter, APB output registers.

## Test plan
- Single write, req0 addr 0x010 data 0xA5, apb_done 3 cycles after transfer -> write bus 0x010/0xA5 stable, rsp_valid[0] one cycle, rsp_err 0.
- Single read, req1 addr 0x105, master returns 0x3C -> rsp_rdata 0x3C with rsp_valid[1]; apb_write_paddr 0 throughout.
- Both req_valid held continuously, 4 transactions -> grant order 0,1,0,1; transfer low one cycle between each.
- TIMEOUT=8, apb_done never asserted -> transfer high exactly 8 cycles, then rsp_valid with rsp_err 1, rsp_rdata 0.
- apb_done on the timeout cycle -> rsp_err 0, data captured.
- preset asserted mid-XFER -> all outputs 0 immediately, no rsp_valid; after release, a new req0 is granted first (rr_ptr 0).
